reset_seq_gen: RTL and testbench

//  Parametrised multi-channel reset sequencer for the processor subsystem and its testbench.

---
 rtl/reset_seq_gen_if.sv | 41 ++++
 rtl/reset_seq_gen.sv | 146 ++++++++++++++
 tb/tb_reset_seq_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_gen_if.sv
// ----------------------------------------------------------------------------
// reset_seq_gen_if
//  Bundles the sequencer's control inputs and reset/status outputs.
//  NUM_CH must match the NUM_CH of the reset_seq_gen instance it connects to.
//
//  Signals
//   LOCK        clock-source lock, asynchronous to CLK
//   SW_RST_REQ  one-cycle pulse requesting a new release sequence
//   CH_MASK     1 = keep that channel in reset for the current sequence
//   RESETn      active-low channel resets, released in index order
//   READY       every release slot of the current sequence has completed
//   STAGE       index of the next channel to release (NUM_CH when done)
//   SEQ_COUNT   completed sequences, saturating at 255
//
//  Modports
//   master  drives the inputs, observes the resets/status (system side)
//   slave   the sequencer itself
// ----------------------------------------------------------------------------
interface reset_seq_gen_if #(
   parameter int NUM_CH = 4
) ();
   localparam int STG_W = $clog2(NUM_CH + 1);

   logic              LOCK;
   logic              SW_RST_REQ;
   logic [NUM_CH-1:0] CH_MASK;
   logic [NUM_CH-1:0] RESETn;
   logic              READY;
   logic [STG_W-1:0]  STAGE;
   logic [7:0]        SEQ_COUNT;

   modport master (
      output LOCK, SW_RST_REQ, CH_MASK,
      input  RESETn, READY, STAGE, SEQ_COUNT
   );

   modport slave (
      input  LOCK, SW_RST_REQ, CH_MASK,
      output RESETn, READY, STAGE, SEQ_COUNT
   );
endinterface

// File: rtl/reset_seq_gen.sv
// ----------------------------------------------------------------------------
// reset_seq_gen
//  Multi-channel reset sequencer. Waits for a filtered clock-lock indication,
//  holds for HOLD_CYCLES, then releases active-low channel resets one at a
//  time every STAGE_CYCLES. Channels can be masked (kept in reset), the whole
//  sequence can be re-run by software, and loss of lock drops every channel
//  back into reset and restarts from lock qualification.
//
//  Ports
//   CLK    in  single clock, rising edge
//   RESET  in  synchronous active-high reset
//   bus    reset_seq_gen_if.slave: LOCK, SW_RST_REQ, CH_MASK in;
//          RESETn, READY, STAGE, SEQ_COUNT out
// ----------------------------------------------------------------------------
module reset_seq_gen #(
   parameter int NUM_CH       = 4,
   parameter int HOLD_CYCLES  = 16,
   parameter int STAGE_CYCLES = 8,
   parameter int LOCK_FILTER  = 4,
   parameter int CNT_W        = 16
) (
   input  logic           CLK,
   input  logic           RESET,
   reset_seq_gen_if.slave bus
);
   localparam int STG_W  = $clog2(NUM_CH + 1);
   localparam int FILT_W = $clog2(LOCK_FILTER + 1);

   typedef enum logic [1:0] {
      S_WAIT_LOCK,
      S_HOLD,
      S_RELEASE,
      S_DONE
   } state_t;

   state_t            r_state;
   logic              r_lock_meta;
   logic              r_lock_s;
   logic [FILT_W-1:0] r_filter;
   logic [CNT_W-1:0]  r_cnt;
   logic [NUM_CH-1:0] r_resetn;
   logic              r_ready;
   logic [STG_W-1:0]  r_stage;
   logic [7:0]        r_seq_count;

   // Bit set for the channel whose slot is current, unless it is masked.
   // r_stage is 0 throughout HOLD, so the same vector serves the channel-0
   // release at the end of HOLD and every later slot in RELEASE.
   logic [NUM_CH-1:0] w_slot_rel;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
         assign w_slot_rel[gi] = (r_stage == STG_W'(gi)) && !bus.CH_MASK[gi];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= S_WAIT_LOCK;
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
         r_filter    <= '0;
         r_cnt       <= '0;
         r_resetn    <= '0;
         r_ready     <= 1'b0;
         r_stage     <= '0;
         r_seq_count <= '0;
      end else begin
         r_lock_meta <= bus.LOCK;
         r_lock_s    <= r_lock_meta;

         if (r_state != S_WAIT_LOCK && !r_lock_s) begin
            // Lock loss is acted on immediately (no filtering) and takes
            // priority over a simultaneous software request.
            r_state  <= S_WAIT_LOCK;
            r_filter <= '0;
            r_cnt    <= '0;
            r_resetn <= '0;
            r_ready  <= 1'b0;
            r_stage  <= '0;
         end else if (r_state != S_WAIT_LOCK && bus.SW_RST_REQ) begin
            // Lock is still good, so skip re-qualification and restart HOLD.
            r_state  <= S_HOLD;
            r_cnt    <= '0;
            r_resetn <= '0;
            r_ready  <= 1'b0;
            r_stage  <= '0;
         end else begin
            case (r_state)
               S_WAIT_LOCK: begin
                  if (!r_lock_s) begin
                     r_filter <= '0;
                  end else if (r_filter == FILT_W'(LOCK_FILTER - 1)) begin
                     r_filter <= FILT_W'(LOCK_FILTER);
                     r_cnt    <= '0;
                     r_state  <= S_HOLD;
                  end else begin
                     r_filter <= r_filter + FILT_W'(1);
                  end
               end

               S_HOLD: begin
                  if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                     r_resetn <= r_resetn | w_slot_rel;
                     r_stage  <= r_stage + STG_W'(1);
                     r_cnt    <= '0;
                     r_state  <= S_RELEASE;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end

               S_RELEASE: begin
                  if (r_stage == STG_W'(NUM_CH)) begin
                     // Last slot was taken on the previous edge.
                     r_state <= S_DONE;
                     r_ready <= 1'b1;
                     if (r_seq_count != 8'hFF) begin
                        r_seq_count <= r_seq_count + 8'd1;
                     end
                  end else if (r_cnt == CNT_W'(STAGE_CYCLES - 1)) begin
                     r_resetn <= r_resetn | w_slot_rel;
                     r_stage  <= r_stage + STG_W'(1);
                     r_cnt    <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end

               S_DONE: begin
                  // Outputs hold; CH_MASK is ignored until the next sequence.
               end

               default: r_state <= S_WAIT_LOCK;
            endcase
         end
      end
   end

   assign bus.RESETn    = r_resetn;
   assign bus.READY     = r_ready;
   assign bus.STAGE     = r_stage;
   assign bus.SEQ_COUNT = r_seq_count;

endmodule

// File: tb/tb_reset_seq_gen.sv
// ----------------------------------------------------------------------------
// tb_reset_seq_gen
//  Directed bench for reset_seq_gen with default parameters. Edge numbers
//  follow the sequencer's convention: edge n is the nth rising edge with
//  RESET low. Inputs change 1 time unit after an edge, outputs are read at
//  the same point, so inputs set after edge n are sampled at edge n+1.
// ----------------------------------------------------------------------------
module tb_reset_seq_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_pass  = 0;
   int n_total = 0;

   int e = 0;          // current edge number
   int rise[4];        // first edge each RESETn bit was seen high
   int ready_at;       // first edge READY was seen high

   reset_seq_gen_if #(.NUM_CH(4)) bus ();

   reset_seq_gen #(
      .NUM_CH(4), .HOLD_CYCLES(16), .STAGE_CYCLES(8), .LOCK_FILTER(4), .CNT_W(16)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic clear_rec();
      for (int i = 0; i < 4; i++) rise[i] = -1;
      ready_at = -1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rst) e = 0;
      else     e = e + 1;
      for (int i = 0; i < 4; i++)
         if (bus.RESETn[i] && rise[i] < 0) rise[i] = e;
      if (bus.READY && ready_at < 0) ready_at = e;
   endtask

   task automatic run_to(input int n);
      while (e < n) step();
   endtask

   task automatic apply_reset(input logic lock);
      bus.LOCK = lock;
      bus.SW_RST_REQ = 1'b0;
      rst = 1'b1;
      repeat (5) step();
      rst = 1'b0;
      clear_rec();
   endtask

   task automatic test_reset();
      bus.CH_MASK = 4'b0000;
      apply_reset(1'b0);
      n_total++; if (bus.RESETn !== 4'b0000) $display("FAIL reset_resetn got %b want 0000", bus.RESETn); else n_pass++;
      n_total++; if (bus.READY !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.READY); else n_pass++;
      n_total++; if (bus.STAGE !== 3'd0) $display("FAIL reset_stage got %0d want 0", bus.STAGE); else n_pass++;
      n_total++; if (bus.SEQ_COUNT !== 8'd0) $display("FAIL reset_seqcnt got %0d want 0", bus.SEQ_COUNT); else n_pass++;
   endtask

   task automatic test_sequence();
      bus.CH_MASK = 4'b0000;
      apply_reset(1'b1);
      run_to(21);
      n_total++; if (bus.STAGE !== 3'd0) $display("FAIL seq_stage_e21 got %0d want 0", bus.STAGE); else n_pass++;
      n_total++; if (bus.RESETn !== 4'b0000) $display("FAIL seq_resetn_e21 got %b want 0000", bus.RESETn); else n_pass++;
      run_to(22);
      n_total++; if (bus.STAGE !== 3'd1) $display("FAIL seq_stage_e22 got %0d want 1", bus.STAGE); else n_pass++;
      run_to(50);
      n_total++; if (rise[0] !== 22) $display("FAIL seq_rise0 got %0d want 22", rise[0]); else n_pass++;
      n_total++; if (rise[1] !== 30) $display("FAIL seq_rise1 got %0d want 30", rise[1]); else n_pass++;
      n_total++; if (rise[2] !== 38) $display("FAIL seq_rise2 got %0d want 38", rise[2]); else n_pass++;
      n_total++; if (rise[3] !== 46) $display("FAIL seq_rise3 got %0d want 46", rise[3]); else n_pass++;
      n_total++; if (ready_at !== 47) $display("FAIL seq_ready_edge got %0d want 47", ready_at); else n_pass++;
      n_total++; if (bus.SEQ_COUNT !== 8'd1) $display("FAIL seq_seqcnt got %0d want 1", bus.SEQ_COUNT); else n_pass++;
      n_total++; if (bus.STAGE !== 3'd4) $display("FAIL seq_stage_done got %0d want 4", bus.STAGE); else n_pass++;
   endtask

   // Continues from the DONE state left by test_sequence.
   task automatic test_sw_resequence();
      run_to(60);
      bus.SW_RST_REQ = 1'b1;
      step();
      bus.SW_RST_REQ = 1'b0;
      n_total++; if (bus.RESETn !== 4'b0000) $display("FAIL sw_resetn_e61 got %b want 0000", bus.RESETn); else n_pass++;
      n_total++; if (bus.READY !== 1'b0) $display("FAIL sw_ready_e61 got %b want 0", bus.READY); else n_pass++;
      n_total++; if (bus.STAGE !== 3'd0) $display("FAIL sw_stage_e61 got %0d want 0", bus.STAGE); else n_pass++;
      clear_rec();
      run_to(105);
      n_total++; if (rise[0] !== 77) $display("FAIL sw_rise0 got %0d want 77", rise[0]); else n_pass++;
      n_total++; if (rise[1] !== 85) $display("FAIL sw_rise1 got %0d want 85", rise[1]); else n_pass++;
      n_total++; if (rise[2] !== 93) $display("FAIL sw_rise2 got %0d want 93", rise[2]); else n_pass++;
      n_total++; if (rise[3] !== 101) $display("FAIL sw_rise3 got %0d want 101", rise[3]); else n_pass++;
      n_total++; if (ready_at !== 102) $display("FAIL sw_ready_edge got %0d want 102", ready_at); else n_pass++;
      n_total++; if (bus.SEQ_COUNT !== 8'd2) $display("FAIL sw_seqcnt got %0d want 2", bus.SEQ_COUNT); else n_pass++;
   endtask

   task automatic test_lock_loss();
      bus.CH_MASK = 4'b0000;
      apply_reset(1'b1);
      run_to(32);
      bus.LOCK = 1'b0;      // low during the cycle sampled at edge 33
      step();
      bus.LOCK = 1'b1;
      step();               // edge 34: lock_s just fell, not yet acted on
      n_total++; if (bus.RESETn !== 4'b0011) $display("FAIL lock_resetn_e34 got %b want 0011", bus.RESETn); else n_pass++;
      step();               // edge 35
      n_total++; if (bus.RESETn !== 4'b0000) $display("FAIL lock_resetn_e35 got %b want 0000", bus.RESETn); else n_pass++;
      n_total++; if (bus.READY !== 1'b0) $display("FAIL lock_ready_e35 got %b want 0", bus.READY); else n_pass++;
      n_total++; if (bus.STAGE !== 3'd0) $display("FAIL lock_stage_e35 got %0d want 0", bus.STAGE); else n_pass++;
      // lock_s back high at 35, filter qualifies at 39, ch0 at 55.
      clear_rec();
      run_to(85);
      n_total++; if (rise[0] !== 55) $display("FAIL lock_rise0 got %0d want 55", rise[0]); else n_pass++;
      n_total++; if (rise[3] !== 79) $display("FAIL lock_rise3 got %0d want 79", rise[3]); else n_pass++;
      n_total++; if (ready_at !== 80) $display("FAIL lock_ready_edge got %0d want 80", ready_at); else n_pass++;
      n_total++; if (bus.SEQ_COUNT !== 8'd1) $display("FAIL lock_seqcnt got %0d want 1", bus.SEQ_COUNT); else n_pass++;
   endtask

   task automatic test_mask();
      bus.CH_MASK = 4'b0100;
      apply_reset(1'b1);
      run_to(50);
      n_total++; if (rise[0] !== 22) $display("FAIL mask_rise0 got %0d want 22", rise[0]); else n_pass++;
      n_total++; if (rise[1] !== 30) $display("FAIL mask_rise1 got %0d want 30", rise[1]); else n_pass++;
      n_total++; if (rise[2] !== -1) $display("FAIL mask_rise2 got %0d want -1", rise[2]); else n_pass++;
      n_total++; if (rise[3] !== 46) $display("FAIL mask_rise3 got %0d want 46", rise[3]); else n_pass++;
      n_total++; if (ready_at !== 47) $display("FAIL mask_ready_edge got %0d want 47", ready_at); else n_pass++;
      n_total++; if (bus.RESETn !== 4'b1011) $display("FAIL mask_resetn got %b want 1011", bus.RESETn); else n_pass++;
      bus.CH_MASK = 4'b0000;
   endtask

   task automatic test_priority_and_reset();
      bus.CH_MASK = 4'b0000;
      apply_reset(1'b1);
      run_to(25);
      bus.LOCK = 1'b0;          // lock_s low at edge 27, acted on at 28
      step();
      bus.LOCK = 1'b1;
      step();
      bus.SW_RST_REQ = 1'b1;    // sampled at edge 28 together with lock loss
      step();
      bus.SW_RST_REQ = 1'b0;
      n_total++; if (bus.RESETn !== 4'b0000) $display("FAIL prio_resetn got %b want 0000", bus.RESETn); else n_pass++;
      n_total++; if (bus.STAGE !== 3'd0) $display("FAIL prio_stage got %0d want 0", bus.STAGE); else n_pass++;
      // WAIT_LOCK path: HOLD at 32, ch0 at 48 (HOLD path would give 44).
      clear_rec();
      run_to(60);
      n_total++; if (rise[0] !== 48) $display("FAIL prio_rise0 got %0d want 48", rise[0]); else n_pass++;
      n_total++; if (rise[1] !== 56) $display("FAIL prio_rise1 got %0d want 56", rise[1]); else n_pass++;
      rst = 1'b1;               // mid-RELEASE reset
      step();
      n_total++; if (bus.RESETn !== 4'b0000) $display("FAIL midrst_resetn got %b want 0000", bus.RESETn); else n_pass++;
      n_total++; if (bus.READY !== 1'b0) $display("FAIL midrst_ready got %b want 0", bus.READY); else n_pass++;
      n_total++; if (bus.STAGE !== 3'd0) $display("FAIL midrst_stage got %0d want 0", bus.STAGE); else n_pass++;
      n_total++; if (bus.SEQ_COUNT !== 8'd0) $display("FAIL midrst_seqcnt got %0d want 0", bus.SEQ_COUNT); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_saturation();
      int timeouts;
      timeouts = 0;
      bus.CH_MASK = 4'b0000;
      apply_reset(1'b1);
      run_to(50);
      n_total++; if (bus.SEQ_COUNT !== 8'd1) $display("FAIL sat_first got %0d want 1", bus.SEQ_COUNT); else n_pass++;
      // 254 more sequences -> 255 total.
      for (int k = 0; k < 254; k++) begin
         bus.SW_RST_REQ = 1'b1;
         step();
         bus.SW_RST_REQ = 1'b0;
         for (int w = 0; w < 60 && !bus.READY; w++) step();
         if (!bus.READY) timeouts++;
      end
      n_total++; if (timeouts !== 0) $display("FAIL sat_timeouts got %0d want 0", timeouts); else n_pass++;
      n_total++; if (bus.SEQ_COUNT !== 8'd255) $display("FAIL sat_255 got %0d want 255", bus.SEQ_COUNT); else n_pass++;
      // 256th sequence must not wrap.
      bus.SW_RST_REQ = 1'b1;
      step();
      bus.SW_RST_REQ = 1'b0;
      for (int w = 0; w < 60 && !bus.READY; w++) step();
      n_total++; if (bus.READY !== 1'b1) $display("FAIL sat_last_ready got %b want 1", bus.READY); else n_pass++;
      n_total++; if (bus.SEQ_COUNT !== 8'd255) $display("FAIL sat_hold got %0d want 255", bus.SEQ_COUNT); else n_pass++;
   endtask

   initial begin
      bus.LOCK       = 1'b0;
      bus.SW_RST_REQ = 1'b0;
      bus.CH_MASK    = 4'b0000;
      clear_rec();
      test_reset();
      test_sequence();
      test_sw_resequence();
      test_lock_loss();
      test_mask();
      test_priority_and_reset();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
